// File: rtl/vector_load_unit.sv
// ----------------------------------------------------------------------------
// vector_load_unit
//
// Purpose:
// - Strided gather of four 32-bit elements into one vector register.
// - Lane i is read from base_addr + i*stride, one request at a time.
// - The assembled vector is committed through the register file write port
//   in a single cycle.
//
// Ports:
// - clk, rst         : clock, asynchronous active-high reset.
// - start, base_addr,
//   stride, dest     : load command. It is sampled only while idle.
// - lane_mask        : lanes to skip (bit = 1 means skip). This port exists
//                      only when VLOAD_LANE_MASK_EN is defined.
// - busy             : high in every state except IDLE.
// - done             : one-cycle pulse, coincident with vwren.
// - err              : one-cycle pulse after a command with dest >= NUM_VREGS.
// - mem_req/mem_addr : read request. It is held until mem_gnt.
// - mem_gnt          : request accepted.
// - mem_rvalid,
//   mem_rdata        : read response.
// - vwren, vwraddr,
//   vwrdata          : register file write port. vwrdata always shows the
//                      collect buffer.
//
// Configuration:
// - Define VLOAD_LANE_MASK_EN to add the per-lane skip mask.
// ----------------------------------------------------------------------------
module vector_load_unit #(
  parameter int ADDR_W    = 32,
  parameter int NUM_VREGS = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [3:0]        dest,
`ifdef VLOAD_LANE_MASK_EN
  input  logic [3:0]        lane_mask,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              vwren,
  output logic [3:0]        vwraddr,
  output logic [31:0]       vwrdata [3:0]
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT} state_e;

  state_e            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [3:0]        dest_q, dest_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       buffer_q [3:0];
  logic [31:0]       buffer_d [3:0];
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              vwren_q, vwren_d;

  logic [3:0]        mask_in;
  logic              advance;
  logic [2:0]        nxt_lane;
  logic [ADDR_W-1:0] addr_base;
  logic [ADDR_W-1:0] addr_stride;

`ifdef VLOAD_LANE_MASK_EN
  assign mask_in = lane_mask;
`else
  assign mask_in = 4'h0;
`endif

  // Lowest unmasked lane at index >= from.
  // Returns 4 when no such lane exists, which means "go to COMMIT".
  function automatic logic [2:0] first_lane(input logic [3:0] mask, input logic [2:0] from);
    first_lane = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(from) && !mask[i]) first_lane = 3'(i);
    end
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned (no latches).
    state_d     = state_q;
    lane_d      = lane_q;
    base_d      = base_q;
    stride_d    = stride_q;
    dest_d      = dest_q;
    mask_d      = mask_q;
    buffer_d    = buffer_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    vwren_d     = 1'b0;
    advance     = 1'b0;
    nxt_lane    = 3'd4;
    addr_base   = base_q;
    addr_stride = stride_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (int'(dest) < NUM_VREGS) begin
            base_d      = base_addr;
            stride_d    = stride;
            dest_d      = dest;
            mask_d      = mask_in;
            buffer_d    = '{default: '0};
            addr_base   = base_addr;
            addr_stride = stride;
            nxt_lane    = first_lane(mask_in, 3'd0);
            advance     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (mem_gnt) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          buffer_d[lane_q] = mem_rdata;
          nxt_lane         = first_lane(mask_q, {1'b0, lane_q} + 3'd1);
          advance          = 1'b1;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        lane_d  = 2'd0;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared step to the next lane.
    // It is used both when a command is accepted and after each response.
    if (advance) begin
      if (nxt_lane[2]) begin
        state_d = S_COMMIT;
        vwren_d = 1'b1;
        done_d  = 1'b1;
      end else begin
        state_d    = S_ISSUE;
        lane_d     = nxt_lane[1:0];
        mem_req_d  = 1'b1;
        // Modular arithmetic, so address wrap and negative strides come for free.
        mem_addr_d = addr_base + addr_stride * ADDR_W'(nxt_lane[1:0]);
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lane_q     <= 2'd0;
      base_q     <= '0;
      stride_q   <= '0;
      dest_q     <= '0;
      mask_q     <= '0;
      // NOTE: the buffer is reset even though it is storage, because vwrdata exposes it and must read zero after reset.
      buffer_q   <= '{default: '0};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      vwren_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
      state_q    <= state_d;
      lane_q     <= lane_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      dest_q     <= dest_d;
      mask_q     <= mask_d;
      buffer_q   <= buffer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      vwren_q    <= vwren_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign vwren    = vwren_q;
  assign vwraddr  = dest_q;
  assign vwrdata  = buffer_q;

endmodule

// File: tb/tb_vector_load_unit.sv
// ----------------------------------------------------------------------------
// tb_vector_load_unit
//
// How the bench works:
// - The whole run is planned ahead as a per-cycle timeline.
// - For every cycle it records the inputs to drive and the outputs required.
// - The timeline is built from the load rules:
//   - one idle cycle samples the command;
//   - each lane takes (grant delay + 1) ISSUE cycles and
//     (response delay + 1) WAIT cycles;
//   - one COMMIT cycle follows the last lane.
// - A single process then replays the timeline:
//   - on each falling edge it compares the DUT with the expected row;
//   - it then drives that cycle's inputs.
// - Cycle c is the interval between rising edges c-1 and c.
// ----------------------------------------------------------------------------
module tb_vector_load_unit;

  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] stride;
  logic [3:0]  dest;
`ifdef VLOAD_LANE_MASK_EN
  logic [3:0]  lane_mask;
`endif
  logic        busy, done, err, mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        vwren;
  logic [3:0]  vwraddr;
  logic [31:0] vwrdata [3:0];

  vector_load_unit #(.ADDR_W(32), .NUM_VREGS(9)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride), .dest(dest),
`ifdef VLOAD_LANE_MASK_EN
    .lane_mask(lane_mask),
`endif
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .vwren(vwren), .vwraddr(vwraddr), .vwrdata(vwrdata)
  );

  always #5 clk = ~clk;

  // Per-cycle stimulus.
  logic        drv_rst [N];
  logic        drv_start [N];
  logic        drv_gnt [N];
  logic        drv_rvalid [N];
  logic [31:0] drv_base [N];
  logic [31:0] drv_stride [N];
  logic [31:0] drv_rdata [N];
  logic [3:0]  drv_dest [N];
`ifdef VLOAD_LANE_MASK_EN
  logic [3:0]  drv_mask [N];
`endif

  // Per-cycle expected outputs. exp_buf packs lane i at bits [32*i +: 32].
  logic         exp_busy [N];
  logic         exp_done [N];
  logic         exp_err [N];
  logic         exp_req [N];
  logic         exp_vwren [N];
  logic [31:0]  exp_addr [N];
  logic [3:0]   exp_vwraddr [N];
  logic [127:0] exp_buf [N];

  int           t;         // first cycle not yet planned
  logic [127:0] cur_buf;   // buffer content carried across planned cycles
  logic         pend_err;  // err owed to the next planned idle cycle
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string name, input int cyc, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Idle cycle. Stray gnt/rvalid pulses are driven here and must be ignored.
  task automatic write_idle(input int c);
    exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_req[c] = 1'b0; exp_vwren[c] = 1'b0;
    exp_addr[c] = '0; exp_vwraddr[c] = '0;
    exp_err[c]  = pend_err;
    pend_err    = 1'b0;
    exp_buf[c]  = cur_buf;
    drv_start[c] = 1'b0;
    drv_gnt[c]    = 1'($urandom);
    drv_rvalid[c] = 1'($urandom);
    drv_rdata[c]  = $urandom;
  endtask

  // Busy cycle. With noise on, commands arrive that must be ignored.
  task automatic write_busy(input int c, input bit noise);
    exp_busy[c] = 1'b1; exp_done[c] = 1'b0; exp_err[c] = 1'b0; exp_req[c] = 1'b0;
    exp_vwren[c] = 1'b0; exp_addr[c] = '0; exp_vwraddr[c] = '0;
    exp_buf[c]  = cur_buf;
    drv_gnt[c] = 1'b0; drv_rvalid[c] = 1'b0; drv_rdata[c] = $urandom;
    drv_start[c]  = noise ? 1'($urandom) : 1'b0;
    drv_dest[c]   = 4'($urandom);
    drv_base[c]   = $urandom;
    drv_stride[c] = $urandom;
`ifdef VLOAD_LANE_MASK_EN
    drv_mask[c] = 4'($urandom);
`endif
  endtask

  task automatic plan_idle(input int n);
    for (int k = 0; k < n; k++) begin
      write_idle(t);
      t++;
    end
  endtask

  task automatic plan_illegal(input logic [3:0] d);
    write_idle(t);
    drv_start[t] = 1'b1; drv_dest[t] = d; drv_base[t] = $urandom; drv_stride[t] = $urandom;
`ifdef VLOAD_LANE_MASK_EN
    drv_mask[t] = 4'h0;
`endif
    pend_err = 1'b1;
    t++;
  endtask

  // Plan one load. The command is driven in cycle t0.
  // - gfix/rfix >= 0 fix the grant/response delay; -1 picks a random 0..3.
  // - rst_at > 0 asserts reset in cycle t0 + rst_at.
  task automatic plan_load(input logic [31:0] base, input logic [31:0] strd, input logic [3:0] d,
                           input logic [3:0] mask, input int gfix, input int rfix, input bit noise,
                           input bit xor_data, input int rst_at, output int t0);
    int c, g, r, rc;
    logic [31:0] addr, data;
    t0 = t;
    write_idle(t0);
    drv_start[t0] = 1'b1; drv_base[t0] = base; drv_stride[t0] = strd; drv_dest[t0] = d;
`ifdef VLOAD_LANE_MASK_EN
    drv_mask[t0] = mask;
`endif
    cur_buf = '0;
    c = t0 + 1;
    for (int i = 0; i < 4; i++) begin
      if (!mask[i]) begin
        addr = base + strd * 32'(i);
        data = xor_data ? (addr ^ 32'hA5A5A5A5) : $urandom;
        g = (gfix >= 0) ? gfix : int'($urandom_range(3, 0));
        r = (rfix >= 0) ? rfix : int'($urandom_range(3, 0));
        for (int k = 0; k <= g; k++) begin
          write_busy(c, noise);
          exp_req[c]    = 1'b1;
          exp_addr[c]   = addr;
          drv_gnt[c]    = (k == g);
          drv_rvalid[c] = noise ? 1'($urandom) : 1'b0;
          c++;
        end
        for (int k = 0; k <= r; k++) begin
          write_busy(c, noise);
          drv_gnt[c]    = (k < r) ? (noise ? 1'($urandom) : 1'b0) : 1'b0;
          drv_rvalid[c] = (k == r);
          if (k == r) drv_rdata[c] = data;
          c++;
        end
        cur_buf[32*i +: 32] = data;
      end
    end
    write_busy(c, noise);
    exp_done[c] = 1'b1; exp_vwren[c] = 1'b1; exp_vwraddr[c] = d;
    t = c + 1;
    if (rst_at > 0 && t0 + rst_at < t) begin
      rc = t0 + rst_at;
      drv_rst[rc] = 1'b1;
      cur_buf = '0;
      for (int k = rc + 1; k < t; k++) write_idle(k);
      t = rc + 1;
    end
  endtask

  task automatic apply(input int c);
    rst        = drv_rst[c];
    start      = drv_start[c];
    base_addr  = drv_base[c];
    stride     = drv_stride[c];
    dest       = drv_dest[c];
    mem_gnt    = drv_gnt[c];
    mem_rvalid = drv_rvalid[c];
    mem_rdata  = drv_rdata[c];
`ifdef VLOAD_LANE_MASK_EN
    lane_mask  = drv_mask[c];
`endif
  endtask

  initial begin : main
    int t0, total;
    for (int c = 0; c < N; c++) begin
      drv_rst[c] = 1'b0; drv_start[c] = 1'b0; drv_gnt[c] = 1'b0; drv_rvalid[c] = 1'b0;
      drv_base[c] = '0; drv_stride[c] = '0; drv_rdata[c] = '0; drv_dest[c] = '0;
`ifdef VLOAD_LANE_MASK_EN
      drv_mask[c] = '0;
`endif
    end
    cur_buf = '0; pend_err = 1'b0; t = 0;
    write_idle(0); drv_rst[0] = 1'b1;
    write_idle(1); drv_rst[1] = 1'b1;
    t = 2;

    // Basic zero-wait load.
    // A command with dest 5 arrives in relative cycle 3 and must be ignored.
    plan_load(32'h100, 32'd4, 4'd2, 4'h0, 0, 0, 1'b0, 1'b1, 0, t0);
    drv_start[t0+3] = 1'b1; drv_dest[t0+3] = 4'd5;
    check("pin_addr_l0", t0+1, exp_addr[t0+1], 32'h100);
    check("pin_addr_l3", t0+7, exp_addr[t0+7], 32'h10C);
    check("pin_commit", t0+9, exp_vwren[t0+9], 1'b1);
    check("pin_data", t0+9, exp_buf[t0+9], {32'hA5A5A4A9, 32'hA5A5A4AD, 32'hA5A5A4A1, 32'hA5A5A4A5});

    // Stalled load: grant after 2 cycles, response after 3 cycles, per lane.
    plan_load(32'h2000, 32'd16, 4'd7, 4'h0, 2, 3, 1'b1, 1'b1, 0, t0);
    check("pin_stall_commit", t0+29, exp_vwren[t0+29], 1'b1);

    // Address wrap, then a negative stride.
    plan_load(32'hFFFFFFF8, 32'd8, 4'd0, 4'h0, 0, 0, 1'b0, 1'b1, 0, t0);
    check("pin_wrap_l1", t0+3, exp_addr[t0+3], 32'h0);
    check("pin_wrap_l3", t0+7, exp_addr[t0+7], 32'h10);
    plan_load(32'h1000, 32'hFFFFFFFC, 4'd8, 4'h0, 0, 0, 1'b1, 1'b1, 0, t0);
    check("pin_neg_l3", t0+7, exp_addr[t0+7], 32'hFF4);

    // Illegal destinations.
    plan_illegal(4'd9);
    plan_illegal(4'd15);
    plan_idle(2);

    // Reset in relative cycle 5, then a fresh load to dest 1.
    plan_load(32'h300, 32'd4, 4'd3, 4'h0, 0, 0, 1'b1, 1'b1, 5, t0);
    plan_idle(1);
    plan_load(32'h400, 32'd4, 4'd1, 4'h0, 0, 0, 1'b0, 1'b1, 0, t0);

`ifdef VLOAD_LANE_MASK_EN
    plan_load(32'h500, 32'd4, 4'd4, 4'b0101, 0, 0, 1'b0, 1'b1, 0, t0);
    check("pin_mask_addr", t0+1, exp_addr[t0+1], 32'h504);
    check("pin_mask_commit", t0+5, exp_vwren[t0+5], 1'b1);
    plan_load(32'h600, 32'd4, 4'd6, 4'hF, 0, 0, 1'b0, 1'b1, 0, t0);
    check("pin_mask_all", t0+1, exp_vwren[t0+1], 1'b1);
`endif

    // Randomised mix of loads, illegal commands, idle gaps and resets.
    while (t < N - 200) begin
      int kind;
      logic [3:0] m;
      kind = int'($urandom_range(9, 0));
      m = 4'h0;
`ifdef VLOAD_LANE_MASK_EN
      if ($urandom_range(3, 0) == 0) m = 4'($urandom);
`endif
      if (kind == 0) plan_illegal(4'(9 + $urandom_range(6, 0)));
      else if (kind == 1) plan_idle(int'($urandom_range(3, 1)));
      else plan_load($urandom, $urandom, 4'($urandom_range(8, 0)), m, -1, -1, 1'($urandom), 1'b0,
                     (kind == 2) ? int'($urandom_range(8, 1)) : 0, t0);
    end
    plan_idle(3);
    total = t;

    // Replay the timeline.
    apply(0);
    for (int c = 1; c < total; c++) begin
      @(negedge clk);
      check("busy", c, busy, exp_busy[c]);
      check("done", c, done, exp_done[c]);
      check("err", c, err, exp_err[c]);
      check("mem_req", c, mem_req, exp_req[c]);
      check("vwren", c, vwren, exp_vwren[c]);
      if (exp_req[c]) check("mem_addr", c, mem_addr, exp_addr[c]);
      if (exp_vwren[c]) check("vwraddr", c, vwraddr, exp_vwraddr[c]);
      check("vwrdata", c, {vwrdata[3], vwrdata[2], vwrdata[1], vwrdata[0]}, exp_buf[c]);
      if (c == 1) begin
        check("reset_mem_addr", c, mem_addr, 32'h0);
        check("reset_vwraddr", c, vwraddr, 4'h0);
      end
      apply(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_load_unit.md
# vector_load_unit

Sequential gather engine that fills one vector register of the CPU's vector register file: four 32-bit elements at base, base+stride, base+2·stride and base+3·stride are fetched from data memory one element at a time, assembled into a 4-lane vector, and committed through the register file's single write port in one cycle. It sits between the vector execute stage, which issues load commands, and the vector register file, whose `wren`/`wraddr`/`wrdata` port it drives.

## Interface
- `ADDR_W`, 32, memory address width; also the width of `base_addr` and `stride`.
- `NUM_VREGS`, 9, number of implemented vector registers; valid destinations are 0..NUM_VREGS-1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_W  byte address of lane 0.
- `stride`  in  ADDR_W  byte stride between lanes.
- `dest`  in  4  destination vector register.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse, coincident with the register file write.
- `err`  out  1  one-cycle pulse on rejection of a command with an illegal `dest`.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  ADDR_W  address of the current request.
- `mem_gnt`  in  1  memory accepted the request this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.
- `vwren`  out  1  register file write enable.
- `vwraddr`  out  4  register file write address.
- `vwrdata`  out  32×4 (unpacked `[3:0]`)  vector to write; index i is lane i.

## Operation
- States: IDLE, ISSUE, WAIT, COMMIT. A 2-bit lane counter selects the current lane.
- IDLE → ISSUE:
  - Occurs when `start`=1 and `dest` < NUM_VREGS.
  - Captures `base_addr`, `stride` and `dest`; lane=0; the collect buffer is cleared to 0.
- Illegal destination:
  - When `start`=1 and `dest` ≥ NUM_VREGS, `err` pulses in the next cycle.
  - No memory request is made, no write occurs, and the state remains IDLE.
- ISSUE:
  - Drives `mem_req`=1 and `mem_addr` = base + lane·stride, truncated to ADDR_W bits; wrap-around is legal.
  - Holds both until `mem_gnt`=1, then moves to WAIT.
- WAIT:
  - On `mem_rvalid`=1, `mem_rdata` is stored into buffer[lane].
  - If lane=3 the next state is COMMIT; otherwise lane increments and the next state is ISSUE.
  - The unit keeps at most one outstanding request.
- COMMIT:
  - For exactly one cycle: `vwren`=1, `vwraddr`=dest, `vwrdata`=buffer, `done`=1.
  - Then returns to IDLE.
- `start` while `busy`=1 is ignored; commands are not queued.
- `mem_rvalid` outside WAIT is ignored.
- `mem_gnt` outside ISSUE is ignored.
- `vwrdata` holds the buffer contents at all times; it is meaningful only while `vwren`=1.

## Timing
- Reset values:
  - State IDLE, lane 0, buffer all zero.
  - All outputs 0, including `mem_addr`, `vwraddr` and `vwrdata`.
- Reset mid-operation aborts the load immediately: no write, no `done`. Any response still in flight afterwards is ignored because the unit is in IDLE.
- All outputs are decoded from registered state; there is no combinational path from inputs to outputs.
- Best case is `mem_gnt` in the first ISSUE cycle and `mem_rvalid` in the first WAIT cycle, with `start` sampled at edge 0:
  - ISSUE in cycles 1, 3, 5, 7.
  - WAIT in cycles 2, 4, 6, 8.
  - COMMIT (`vwren`, `done`) in cycle 9.
  - `busy` is high in cycles 1–9.
- A new `start` is accepted in the first IDLE cycle after COMMIT (cycle 10 in the best case).
- Each cycle of grant or response stall adds exactly one cycle.

## Configuration
- `VLOAD_LANE_MASK_EN` defined:
  - Adds input `lane_mask` (4 bits), captured with the command.
  - Masked lanes (bit=1) issue no memory request and their buffer element stays 0.
  - From IDLE, or from WAIT after the last unmasked lane, the unit advances directly to the next unmasked lane's ISSUE, or to COMMIT if no unmasked lane remains.
  - `lane_mask`=4'hF goes IDLE → COMMIT and writes all zeros in cycle 1.
- `VLOAD_LANE_MASK_EN` undefined: the port is absent and all four lanes are always loaded.

## Test plan
- Basic load: base=0x100, stride=4, dest=2, zero-wait memory returning addr^0xA5A5A5A5 → requests at 0x100/104/108/10C; `vwren` and `done` in cycle 9 with dest 2 and lanes {0xA5A5A4A5, 0xA5A5A4A1, 0xA5A5A4AD, 0xA5A5A4A9}.
- Stalls: `mem_gnt` delayed 2 cycles and `rvalid` delayed 3 cycles per lane → `mem_addr` stable while waiting; commit in cycle 9+20=29; data is correct.
- Wrap and negative stride: base=0xFFFFFFF8, stride=8 → addresses 0xFFFFFFF8, 0x0, 0x8, 0x10. With stride=0xFFFFFFFC (−4) → descending addresses.
- Illegal dest: `dest`=9 and `dest`=15 → `err` pulses one cycle; `mem_req`, `vwren` and `busy` stay 0.
- Start while busy and spurious `rvalid`: `start` with dest=5 in cycle 3, plus `mem_rvalid` during ISSUE → ignored; the write goes to the original dest with the original data.
- Reset in cycle 5, then a new command with dest=1 → no write to the first dest; the second load completes normally. With `VLOAD_LANE_MASK_EN` and mask=4'b0101 → only lanes 1 and 3 are requested; lanes 0 and 2 are written as 0.
